// File: rtl/maxpool_pkg.sv
// Shared types, constants and width helpers for the binary 2x2 max-pool controller.
package maxpool_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int unsigned DRAIN_CYC = 2;
    localparam int unsigned IMG_W_DEF = 16;
    localparam int unsigned IMG_H_DEF = 16;

    // Bits needed to count n positions; never below 1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

    // Bits needed for a pooled (stride-2) index over n input positions.
    function automatic int unsigned pool_w(input int unsigned n);
        return (n <= 32'd4) ? 32'd1 : 32'($clog2(n)) - 32'd1;
    endfunction

endpackage

// File: rtl/maxpool_ctrl_if.sv
// Stream, datapath and status signals of maxpool_ctrl; slave = controller view.
// oCYCLES exists only when MAXPOOL_CTRL_CYCCNT_EN is defined.
interface maxpool_ctrl_if #(
    parameter int unsigned PRW = 3,
    parameter int unsigned PCW = 3
);
    logic           iSTART;
    logic           iVALID;
    logic           iDATA;
    logic           oMP_START;
    logic           oMP_DATA;
    logic           iMP_DATA;
    logic           oVALID;
    logic           oDATA;
    logic [PRW-1:0] oROW;
    logic [PCW-1:0] oCOL;
    logic           oDONE;
    logic           oBUSY;
    logic           oERR;
`ifdef MAXPOOL_CTRL_CYCCNT_EN
    logic [15:0]    oCYCLES;
`endif

    modport slave (
        input  iSTART, iVALID, iDATA, iMP_DATA,
`ifdef MAXPOOL_CTRL_CYCCNT_EN
        output oCYCLES,
`endif
        output oMP_START, oMP_DATA, oVALID, oDATA, oROW, oCOL, oDONE, oBUSY, oERR
    );

    modport master (
        output iSTART, iVALID, iDATA, iMP_DATA,
`ifdef MAXPOOL_CTRL_CYCCNT_EN
        input  oCYCLES,
`endif
        input  oMP_START, oMP_DATA, oVALID, oDATA, oROW, oCOL, oDONE, oBUSY, oERR
    );
endinterface

// File: rtl/raster_cnt.sv
// Raster-scan column/row position counter with clear, enable, wrap and a
// registered flag marking the last pixel of the frame.
module raster_cnt
    import maxpool_pkg::*;
#(
    parameter int unsigned W  = IMG_W_DEF,
    parameter int unsigned H  = IMG_H_DEF,
    parameter int unsigned CW = cnt_w(W),
    parameter int unsigned RW = cnt_w(H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          last_o
);
    logic [CW-1:0] col_q, col_d, col_b;
    logic [RW-1:0] row_q, row_d, row_b;
    logic          last_q, last_d;

    // Clear and enable together restart at (0,0) and count that pixel.
    always_comb begin
        col_b = clr_i ? '0 : col_q;
        row_b = clr_i ? '0 : row_q;
        col_d = col_b;
        row_d = row_b;
        if (en_i) begin
            if (col_b == CW'(W - 1)) begin
                col_d = '0;
                row_d = (row_b == RW'(H - 1)) ? '0 : row_b + RW'(1);
            end else begin
                col_d = col_b + CW'(1);
            end
        end
        last_d = (col_d == CW'(W - 1)) && (row_d == RW'(H - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            last_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            last_q <= last_d;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign last_o = last_q;
endmodule

// File: rtl/maxpool_ctrl.sv
// Sequencer for the binary 2x2 max-pool datapath: forwards the pixel stream and
// qualifies the window OR at stride-2 positions. Optional MAXPOOL_CTRL_CYCCNT_EN adds oCYCLES.
module maxpool_ctrl
    import maxpool_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF
) (
    input logic           iCLK,
    input logic           iRST,
    maxpool_ctrl_if.slave bus
);
    localparam int unsigned CW  = cnt_w(IMG_W);
    localparam int unsigned RW  = cnt_w(IMG_H);
    localparam int unsigned PCW = pool_w(IMG_W);
    localparam int unsigned PRW = pool_w(IMG_H);
    localparam int unsigned DW  = cnt_w(DRAIN_CYC);

    logic           start_acc, run_acc, cnt_en, cnt_last;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;

    state_e         state_q, state_d;
    logic [DW-1:0]  drain_q, drain_d;
    logic           arm_q, arm_d, arm_last_q, arm_last_d;
    logic [PRW-1:0] arm_row_q, arm_row_d, orow_q, orow_d;
    logic [PCW-1:0] arm_col_q, arm_col_d, ocol_q, ocol_d;
    logic           vld_q, vld_d, dat_q, dat_d, done_q, done_d;
    logic           busy_q, busy_d, err_q, err_d;

    assign start_acc = bus.iSTART & bus.iVALID;
    assign run_acc   = (state_q == ST_RUN) & bus.iVALID & ~bus.iSTART;
    assign cnt_en    = start_acc | run_acc;

    assign bus.oMP_START = start_acc;
    assign bus.oMP_DATA  = bus.iDATA;

    raster_cnt #(
        .W (IMG_W),
        .H (IMG_H),
        .CW(CW),
        .RW(RW)
    ) u_cnt (
        .clk   (iCLK),
        .rst_n (iRST),
        .clr_i (start_acc),
        .en_i  (cnt_en),
        .col_o (col),
        .row_o (row),
        .last_o(cnt_last)
    );

    // The window flag is armed on an odd/odd accept; one cycle later the datapath OR is valid.
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        err_d      = err_q;
        arm_d      = 1'b0;
        arm_last_d = 1'b0;
        arm_row_d  = arm_row_q;
        arm_col_d  = arm_col_q;
        vld_d      = arm_q;
        dat_d      = arm_q & bus.iMP_DATA;
        done_d     = arm_q & arm_last_q;
        orow_d     = arm_q ? arm_row_q : orow_q;
        ocol_d     = arm_q ? arm_col_q : ocol_q;
        if (start_acc) begin
            state_d = ST_RUN;
            drain_d = '0;
            err_d   = 1'b0;
            vld_d   = 1'b0;
            dat_d   = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!bus.iVALID) begin
                        // The datapath cannot stall, so a bubble abandons the frame.
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                        vld_d   = 1'b0;
                        dat_d   = 1'b0;
                        done_d  = 1'b0;
                    end else begin
                        arm_d      = row[0] & col[0];
                        arm_last_d = cnt_last;
                        arm_row_d  = PRW'(row >> 1);
                        arm_col_d  = PCW'(col >> 1);
                        if (cnt_last) begin
                            state_d = ST_DRAIN;
                            drain_d = '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DW'(DRAIN_CYC - 1)) state_d = ST_IDLE;
                    else                               drain_d = drain_q + DW'(1);
                end
                default: ;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q    <= ST_IDLE;
            drain_q    <= '0;
            arm_q      <= 1'b0;
            arm_last_q <= 1'b0;
            arm_row_q  <= '0;
            arm_col_q  <= '0;
            vld_q      <= 1'b0;
            dat_q      <= 1'b0;
            done_q     <= 1'b0;
            orow_q     <= '0;
            ocol_q     <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            arm_q      <= arm_d;
            arm_last_q <= arm_last_d;
            arm_row_q  <= arm_row_d;
            arm_col_q  <= arm_col_d;
            vld_q      <= vld_d;
            dat_q      <= dat_d;
            done_q     <= done_d;
            orow_q     <= orow_d;
            ocol_q     <= ocol_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign bus.oVALID = vld_q;
    assign bus.oDATA  = dat_q;
    assign bus.oROW   = orow_q;
    assign bus.oCOL   = ocol_q;
    assign bus.oDONE  = done_q;
    assign bus.oBUSY  = busy_q;
    assign bus.oERR   = err_q;

`ifdef MAXPOOL_CTRL_CYCCNT_EN
    localparam int unsigned CYC_W = 16;
    logic [CYC_W-1:0] cyc_q, cyc_d;

    // The accepting start cycle is the frame's first cycle, so the count restarts at 1.
    always_comb begin
        cyc_d = cyc_q;
        if (start_acc)                                   cyc_d = CYC_W'(1);
        else if ((state_q != ST_IDLE) && (cyc_q != '1))  cyc_d = cyc_q + CYC_W'(1);
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) cyc_q <= '0;
        else       cyc_q <= cyc_d;
    end

    assign bus.oCYCLES = cyc_q;
`endif
endmodule

// File: tb/tb_maxpool_ctrl.sv
// Directed self-checking bench for maxpool_ctrl with a behavioural 2x2 OR datapath.
module tb_maxpool_ctrl;
    localparam int W = 16;
    localparam int H = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   p59      = 0;

    maxpool_ctrl_if #(.PRW(3), .PCW(3)) bus ();

    maxpool_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .iCLK(clk),
        .iRST(rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath: line buffer + 2x2 window + OR, enable tied high.
    logic [W+1:0] sr = '0;
    always @(posedge clk) sr <= {sr[W:0], bus.oMP_DATA};
    assign bus.iMP_DATA = sr[0] | sr[1] | sr[W] | sr[W+1];

    // Output monitor.
    int   vcount = 0, ones = 0, consec = 0, done_cnt = 0, done_vc = 0, one_cyc = 0;
    logic [2:0] done_row = '0, done_col = '0;
    bit   prev_v = 1'b0;
    bit   got  [8][8];
    int   vcyc [8][8];

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.oVALID) begin
                vcount = vcount + 1;
                if (prev_v) consec = consec + 1;
                got[bus.oROW][bus.oCOL]  = bus.oDATA;
                vcyc[bus.oROW][bus.oCOL] = cyc;
                if (bus.oDATA) begin
                    ones    = ones + 1;
                    one_cyc = cyc;
                end
            end
            if (bus.oDONE) begin
                done_cnt = done_cnt + 1;
                done_row = bus.oROW;
                done_col = bus.oCOL;
                done_vc  = vcount;
            end
            prev_v = bus.oVALID;
        end else begin
            prev_v = 1'b0;
        end
    end

    bit frm [H][W];

    task automatic set_frame(input int pat);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (pat)
                    0:       frm[r][c] = 1'b0;
                    1:       frm[r][c] = (r == 5) && (c == 9);
                    2:       frm[r][c] = ((r + c) % 2) == 1;
                    default: frm[r][c] = 1'b1;
                endcase
    endtask

    task automatic drive(input bit s, input bit v, input bit d);
        bus.iSTART = s;
        bus.iVALID = v;
        bus.iDATA  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic run_pix(input int lo, input int hi);
        for (int p = lo; p < hi; p++) begin
            int r, c;
            r = p / W;
            c = p % W;
            if (r == 5 && c == 9) p59 = cyc;
            drive(p == 0, 1'b1, frm[r][c]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        bus.iSTART = 0; bus.iVALID = 0; bus.iDATA = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.oVALID !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.oVALID); end
        checks++; if (bus.oDATA  !== 1'b0) begin failures++; $display("FAIL rst_data got=%b exp=0", bus.oDATA); end
        checks++; if (bus.oDONE  !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus.oDONE); end
        checks++; if (bus.oBUSY  !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.oBUSY); end
        checks++; if (bus.oERR   !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus.oERR); end
        checks++; if (bus.oROW !== 3'd0 || bus.oCOL !== 3'd0) begin failures++; $display("FAIL rst_coord got=%0d,%0d exp=0,0", bus.oROW, bus.oCOL); end
        bus.iDATA = 1'b1;
        #1;
        checks++; if (bus.oMP_DATA !== 1'b1) begin failures++; $display("FAIL mp_data_fwd got=%b exp=1", bus.oMP_DATA); end
        bus.iDATA  = 1'b0;
        bus.iSTART = 1'b1;
        #1;
        checks++; if (bus.oMP_START !== 1'b0) begin failures++; $display("FAIL mp_start_novalid got=%b exp=0", bus.oMP_START); end
        bus.iSTART = 1'b0;
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_idle_ignore;
        int vb;
        vb = vcount;
        repeat (4) drive(1'b0, 1'b1, 1'b1);
        checks++; if (bus.oBUSY !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", bus.oBUSY); end
        idle(3);
        checks++; if (vcount - vb !== 0) begin failures++; $display("FAIL idle_valids got=%0d exp=0", vcount - vb); end
    endtask

    task automatic test_zero_frame;
        int vb, ob, db, cb;
        vb = vcount; ob = ones; db = done_cnt; cb = consec;
        set_frame(0);
        run_pix(0, 1);
        checks++; if (bus.oBUSY !== 1'b1) begin failures++; $display("FAIL zero_busy_start got=%b exp=1", bus.oBUSY); end
        run_pix(1, W * H);
        idle(1);
        checks++; if (bus.oBUSY !== 1'b1) begin failures++; $display("FAIL zero_busy_drain got=%b exp=1", bus.oBUSY); end
        idle(1);
        checks++; if (bus.oBUSY !== 1'b0) begin failures++; $display("FAIL zero_busy_fall got=%b exp=0", bus.oBUSY); end
        idle(4);
        checks++; if (vcount - vb !== 64) begin failures++; $display("FAIL zero_count got=%0d exp=64", vcount - vb); end
        checks++; if (ones - ob !== 0) begin failures++; $display("FAIL zero_ones got=%0d exp=0", ones - ob); end
        checks++; if (done_cnt - db !== 1) begin failures++; $display("FAIL zero_done_cnt got=%0d exp=1", done_cnt - db); end
        checks++; if (done_row !== 3'd7 || done_col !== 3'd7) begin failures++; $display("FAIL zero_done_pos got=%0d,%0d exp=7,7", done_row, done_col); end
        checks++; if (done_vc - vb !== 64) begin failures++; $display("FAIL zero_done_on_last got=%0d exp=64", done_vc - vb); end
        checks++; if (consec - cb !== 0) begin failures++; $display("FAIL zero_consec got=%0d exp=0", consec - cb); end
    endtask

    task automatic test_single;
        int vb, ob;
        vb = vcount; ob = ones;
        set_frame(1);
        run_pix(0, W * H);
        idle(6);
        checks++; if (vcount - vb !== 64) begin failures++; $display("FAIL single_count got=%0d exp=64", vcount - vb); end
        checks++; if (ones - ob !== 1) begin failures++; $display("FAIL single_ones got=%0d exp=1", ones - ob); end
        checks++; if (got[2][4] !== 1'b1) begin failures++; $display("FAIL single_out24 got=%b exp=1", got[2][4]); end
        checks++; if (one_cyc - p59 !== 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", one_cyc - p59); end
    endtask

    task automatic test_checker;
        int ob, bad;
        bit e;
        ob = ones;
        set_frame(2);
        run_pix(0, W * H);
        idle(6);
        checks++; if (ones - ob !== 64) begin failures++; $display("FAIL chk_ones got=%0d exp=64", ones - ob); end
        for (int rr = 0; rr < 8; rr++)
            for (int cc = 0; cc < 8; cc++) begin
                e = frm[2*rr][2*cc] | frm[2*rr][2*cc+1] | frm[2*rr+1][2*cc] | frm[2*rr+1][2*cc+1];
                checks++;
                if (got[rr][cc] !== e) begin failures++; $display("FAIL chk_or_%0d_%0d got=%b exp=%b", rr, cc, got[rr][cc], e); end
            end
        bad = 0;
        for (int rr = 0; rr < 8; rr++)
            for (int cc = 1; cc < 8; cc++)
                if (vcyc[rr][cc] - vcyc[rr][cc-1] != 2) bad++;
        checks++; if (bad !== 0) begin failures++; $display("FAIL chk_spacing got=%0d bad gaps exp=0", bad); end
    endtask

    task automatic test_underrun;
        int vb, db;
        vb = vcount; db = done_cnt;
        set_frame(3);
        run_pix(0, 3 * W + 4);
        drive(1'b0, 1'b0, 1'b1);
        checks++; if (bus.oERR !== 1'b1) begin failures++; $display("FAIL ur_err got=%b exp=1", bus.oERR); end
        checks++; if (bus.oBUSY !== 1'b0) begin failures++; $display("FAIL ur_idle got=%b exp=0", bus.oBUSY); end
        repeat (4) drive(1'b0, 1'b1, 1'b1);
        idle(2);
        checks++; if (bus.oERR !== 1'b1) begin failures++; $display("FAIL ur_sticky got=%b exp=1", bus.oERR); end
        checks++; if (vcount - vb !== 9) begin failures++; $display("FAIL ur_count got=%0d exp=9", vcount - vb); end
        checks++; if (done_cnt - db !== 0) begin failures++; $display("FAIL ur_done got=%0d exp=0", done_cnt - db); end
        vb = vcount; db = done_cnt;
        set_frame(0);
        run_pix(0, 1);
        checks++; if (bus.oERR !== 1'b0) begin failures++; $display("FAIL ur_err_clr got=%b exp=0", bus.oERR); end
        run_pix(1, W * H);
        idle(6);
        checks++; if (vcount - vb !== 64) begin failures++; $display("FAIL ur_next_count got=%0d exp=64", vcount - vb); end
        checks++; if (done_cnt - db !== 1) begin failures++; $display("FAIL ur_next_done got=%0d exp=1", done_cnt - db); end
    endtask

    task automatic test_restart;
        int vb, db;
        vb = vcount; db = done_cnt;
        set_frame(3);
        run_pix(0, 10 * W + 2);
        run_pix(0, 1);
        checks++; if (bus.oBUSY !== 1'b1) begin failures++; $display("FAIL rs_busy got=%b exp=1", bus.oBUSY); end
        run_pix(1, W * H);
        idle(6);
        checks++; if (vcount - vb !== 104) begin failures++; $display("FAIL rs_count got=%0d exp=104", vcount - vb); end
        checks++; if (done_cnt - db !== 1) begin failures++; $display("FAIL rs_done_cnt got=%0d exp=1", done_cnt - db); end
        checks++; if (done_vc - vb !== 104) begin failures++; $display("FAIL rs_done_on_last got=%0d exp=104", done_vc - vb); end
    endtask

    task automatic test_async_reset;
        int vb;
        set_frame(3);
        run_pix(0, W + 3);
        bus.iSTART = 1'b0; bus.iVALID = 1'b1; bus.iDATA = 1'b1;
        checks++; if (bus.oVALID !== 1'b1 || bus.oBUSY !== 1'b1) begin failures++; $display("FAIL ar_pre got=%b%b exp=11", bus.oVALID, bus.oBUSY); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({bus.oVALID, bus.oDATA, bus.oDONE, bus.oBUSY, bus.oERR} !== 5'b0) begin failures++; $display("FAIL ar_flags got=%b exp=00000", {bus.oVALID, bus.oDATA, bus.oDONE, bus.oBUSY, bus.oERR}); end
        checks++; if (bus.oROW !== 3'd0 || bus.oCOL !== 3'd0) begin failures++; $display("FAIL ar_coord got=%0d,%0d exp=0,0", bus.oROW, bus.oCOL); end
        bus.iVALID = 1'b0; bus.iDATA = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        vb = vcount;
        set_frame(0);
        run_pix(0, W * H);
        idle(6);
        checks++; if (vcount - vb !== 64) begin failures++; $display("FAIL ar_next_count got=%0d exp=64", vcount - vb); end
    endtask

`ifdef MAXPOOL_CTRL_CYCCNT_EN
    task automatic test_cyccnt;
        set_frame(0);
        run_pix(0, W * H);
        idle(5);
        checks++; if (bus.oCYCLES !== 16'd258) begin failures++; $display("FAIL cyc_frame got=%0d exp=258", bus.oCYCLES); end
        repeat (3) drive(1'b0, 1'b1, 1'b0);
        checks++; if (bus.oCYCLES !== 16'd258) begin failures++; $display("FAIL cyc_hold got=%0d exp=258", bus.oCYCLES); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_ignore();
        test_zero_frame();
        test_single();
        test_checker();
        test_underrun();
        test_restart();
        test_async_reset();
`ifdef MAXPOOL_CTRL_CYCCNT_EN
        test_cyccnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/maxpool_ctrl.md
Name: maxpool_ctrl

Overview:
Sequencer for the binary 2x2 max-pool datapath (line buffer plus 2x2 register window plus OR).
- Accepts a raster-scanned 1-bit feature map, one pixel per cycle.
- Forwards the stream and frame-start pulse to the datapath.
- Tracks row and column position and qualifies the datapath's OR output only at stride-2 window positions.
- Emits a registered pooled stream with valid, output coordinates, done and error flags. Sits between the preceding binary conv layer and the next layer's input.

Parameters:
IMG_W, 16, input feature-map width in pixels (even, >=4)
IMG_H, 16, input feature-map height in pixels (even, >=2)
CW, $clog2(IMG_W), column counter width (derived)
RW, $clog2(IMG_H), row counter width (derived)

Ports:
iCLK  in  1  clock, rising edge
iRST  in  1  reset, asynchronous, active-low
iSTART  in  1  frame start pulse; qualifies first pixel of frame when iVALID=1
iVALID  in  1  input pixel valid
iDATA  in  1  input pixel
oMP_START  out  1  to datapath iSTART; = iSTART & iVALID, combinational
oMP_DATA  out  1  to datapath iDATA; = iDATA, combinational
iMP_DATA  in  1  datapath OR result (2x2 window max)
oVALID  out  1  pooled output valid, registered
oDATA  out  1  pooled output bit, registered
oROW  out  RW-1  pooled output row index
oCOL  out  CW-1  pooled output column index
oDONE  out  1  one-cycle pulse coincident with last pooled output
oBUSY  out  1  high while a frame is in progress
oERR  out  1  sticky stream-underrun flag

Behaviour:
- Reset (iRST=0, async): state IDLE; counters 0; all outputs 0; pipeline flags cleared.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: iSTART&iVALID -> RUN; pixel (0,0) accepted, col=1, row=0, oERR cleared.
  - RUN: each cycle requires iVALID=1. Advance col; at col=IMG_W-1, wrap col to 0 and increment row. On the accept of pixel (IMG_H-1, IMG_W-1), go to DRAIN.
  - DRAIN: lasts 2 cycles for pipeline flush, then IDLE.
- oBUSY = 1 in RUN and DRAIN.
- Window qualify: accepting pixel (r,c) with r odd and c odd arms a 2-stage flag.
  - Cycle t+1: datapath window holds (r-1..r, c-1..c); iMP_DATA is valid.
  - Cycle t+1 edge: controller registers oDATA<=iMP_DATA, oVALID<=1, oROW<=r>>1, oCOL<=c>>1.
  - Total latency: 2 cycles from accept of bottom-right pixel to oVALID.
- oVALID is high for exactly one cycle per window: (IMG_W/2)*(IMG_H/2) pulses per frame, 64 for defaults. oVALID is never asserted in consecutive cycles.
- oDONE is asserted with the oVALID for output (IMG_H/2-1, IMG_W/2-1).
- Underrun: iVALID=0 while in RUN sets oERR=1 (sticky until the next accepted iSTART). The FSM goes to IDLE, armed flags clear, and no further oVALID is issued for that frame. The datapath cannot stall (enable tied high), so a bubble is unrecoverable.
- iSTART&iVALID in RUN or DRAIN restarts the frame:
  - counters reset to (0,1), state RUN, oERR cleared, oMP_START pulses;
  - any in-flight oVALID from the old frame is suppressed; oDONE is not asserted for the aborted frame.
- iVALID in IDLE without iSTART: ignored; counters hold; oMP_DATA still forwarded.
- In DRAIN, iVALID without iSTART is ignored.

Optional Feature:
Macro MAXPOOL_CTRL_CYCCNT_EN.
- Defined: adds output port oCYCLES (16 bits). It is cleared on an accepted iSTART, increments every cycle in RUN/DRAIN, saturates at 16'hFFFF, and holds its value after oDONE until the next start. Reset value is 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package maxpool_pkg holds:
  - FSM state enum (IDLE, RUN, DRAIN);
  - DRAIN_CYC=2 constant;
  - default IMG_W/IMG_H constants;
  - width helper functions.
- One sub-module, raster_cnt: parameterized col/row counter with clear, enable, wrap and last-pixel flag. It is reusable by other layer controllers.

Test Plan:
- All-zero 16x16 frame, continuous iVALID -> 64 oVALID pulses, all oDATA=0; oDONE on the 64th with oROW=7, oCOL=7; oBUSY falls 2 cycles after the last pixel accept.
- Single 1 at pixel (5,9), else 0 -> only output (2,4) has oDATA=1; oVALID arrives 2 cycles after accept of pixel (5,9).
- Checkerboard frame -> every oDATA=1; oVALID spacing is exactly 2 cycles within a pooled row pair. Also check the datapath's registered result against a reference 2x2 OR model.
- iVALID dropped at pixel (3,4) -> oERR=1 next cycle, FSM IDLE, no further oVALID. oERR is cleared by the next iSTART, and the following frame completes with 64 outputs.
- iSTART reissued at pixel (10,2) mid-frame -> counters restart, no oDONE for the aborted frame, the new frame yields 64 outputs. Async reset asserted mid-frame -> all outputs 0 immediately.
- With MAXPOOL_CTRL_CYCCNT_EN defined: a full frame gives oCYCLES=258 after oDONE (256 RUN cycles plus 2 DRAIN), held until the next start.
